b_req_receiver: RTL and testbench

- B-side responder for the A->B request interface (single-bit Valid plus 12-bit Address, no backpressure toward A).
- Samples every Valid request on the rising clock edge and range-checks the address.
- Buffers requests in a small FIFO and presents them to B-internal logic through a valid/ready handshake.
- A cannot be stalled, so overflow is detected, counted and flagged instead.

---
 rtl/a_b_pkg.sv | 13 +
 rtl/b_req_fifo.sv | 56 +++++
 rtl/b_req_receiver.sv | 96 +++++++++
 tb/tb_b_req_receiver.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/a_b_pkg.sv
// Shared types for the A->B request interface.
package a_b_pkg;

    localparam int unsigned ADDR_W = 12;

    typedef logic [ADDR_W-1:0] addr_t;

    typedef struct packed {
        addr_t addr;
        logic  err;
    } b_req_t;

endpackage

// File: rtl/b_req_fifo.sv
// Synchronous FIFO of b_req_t entries. Occupancy is tracked with an explicit level counter.
module b_req_fifo
    import a_b_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  b_req_t                   wdata,
    input  logic                     pop,
    output b_req_t                   rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    b_req_t          mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [LW-1:0]   level_q;

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;

    // Storage is reset so the head reads as zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/b_req_receiver.sv
// B-side responder: range-checks A requests, buffers them and flags overflow since A cannot stall.
module b_req_receiver
    import a_b_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter addr_t       ADDR_LO = 12'h000,
    parameter addr_t       ADDR_HI = 12'hFFF,
    parameter int unsigned DROP_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     Enable,
    input  logic                     Valid,
    input  logic [ADDR_W-1:0]        Address,
    output logic                     Out_Valid,
    input  logic                     Out_Ready,
    output logic [ADDR_W-1:0]        Out_Address,
    output logic                     Out_Err,
    output logic [$clog2(DEPTH):0]   Level,
    output logic [DROP_W-1:0]        Drop_Count,
    output logic                     Overflow,
    input  logic                     Clr_Overflow
);

    logic              push_req;
    logic              pop;
    logic              fifo_push;
    logic              drop;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   offset;
    b_req_t            wdata;
    b_req_t            head;
    b_req_t            last_q;
    logic [DROP_W-1:0] drop_count_q;
    logic              overflow_q;

    // One extra bit: addresses below ADDR_LO wrap above the span and fail the single compare.
    assign offset     = {1'b0, Address} - {1'b0, ADDR_LO};
    assign wdata.addr = Address;
    assign wdata.err  = (offset > {1'b0, ADDR_HI - ADDR_LO});

    assign push_req  = Enable & Valid;
    assign pop       = ~empty & Out_Ready;
    assign fifo_push = push_req & (~full | pop);
    assign drop      = push_req & full & ~pop;

    b_req_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata (wdata),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (Level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q       <= '0;
            drop_count_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            if (pop) begin
                last_q <= head;
            end
            // A drop in the same cycle as a clear wins over the clear.
            if (drop) begin
                overflow_q <= 1'b1;
                if (Clr_Overflow) begin
                    drop_count_q <= DROP_W'(1);
                end else if (drop_count_q != '1) begin
                    drop_count_q <= drop_count_q + DROP_W'(1);
                end
            end else if (Clr_Overflow) begin
                overflow_q   <= 1'b0;
                drop_count_q <= '0;
            end
        end
    end

    // Once drained, keep presenting the last entry consumed.
    always_comb begin
        Out_Valid   = ~empty;
        Out_Address = empty ? last_q.addr : head.addr;
        Out_Err     = empty ? last_q.err  : head.err;
    end

    assign Drop_Count = drop_count_q;
    assign Overflow   = overflow_q;

endmodule

// File: tb/tb_b_req_receiver.sv
// Self-checking bench for b_req_receiver: vector table, directed corner sequences, random vs queue model.
module tb_b_req_receiver;

    localparam int unsigned DEPTH = 8;
    localparam logic [11:0] LO    = 12'h100;
    localparam logic [11:0] HI    = 12'h1FF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0, vld = 1'b0, rdy = 1'b0, clr = 1'b0;
    logic [11:0] addr = '0;
    logic        out_valid, out_err, ovf;
    logic [11:0] out_addr;
    logic [3:0]  level;
    logic [7:0]  drop_cnt;

    b_req_receiver #(
        .DEPTH   (DEPTH),
        .ADDR_LO (LO),
        .ADDR_HI (HI),
        .DROP_W  (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .Enable       (en),
        .Valid        (vld),
        .Address      (addr),
        .Out_Valid    (out_valid),
        .Out_Ready    (rdy),
        .Out_Address  (out_addr),
        .Out_Err      (out_err),
        .Level        (level),
        .Drop_Count   (drop_cnt),
        .Overflow     (ovf),
        .Clr_Overflow (clr)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [11:0] a;
        logic        e;
    } ent_t;

    ent_t q[$];
    int   m_dc = 0;
    bit   m_ov = 1'b0;

    typedef struct {
        bit          en, v;
        logic [11:0] a;
        bit          r, c;
        bit          xv;
        logic [11:0] xa;
        bit          xe;
        int          xl, xd;
        bit          xo;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the queue model, and stop 1ns past the edge.
    task automatic drive(input bit e, input bit vv, input logic [11:0] a, input bit r,
                         input bit c);
        bit pop, push, full, drop;
        en = e; vld = vv; addr = a; rdy = r; clr = c;
        pop  = (q.size() != 0) && r;
        push = e && vv;
        full = (q.size() == DEPTH);
        drop = push && full && !pop;
        if (pop) void'(q.pop_front());
        if (push && !drop) q.push_back(ent_t'{a, (a < LO) || (a > HI)});
        if (drop) begin
            m_dc = c ? 1 : ((m_dc == 255) ? 255 : m_dc + 1);
            m_ov = 1'b1;
        end else if (c) begin
            m_dc = 0;
            m_ov = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".valid"}, 32'(out_valid), 32'(q.size() != 0));
        chk({tag, ".level"}, 32'(level), 32'(q.size()));
        chk({tag, ".drop"}, 32'(drop_cnt), 32'(m_dc));
        chk({tag, ".ovf"}, 32'(ovf), 32'(m_ov));
        if (q.size() != 0) begin
            chk({tag, ".addr"}, 32'(out_addr), 32'(q[0].a));
            chk({tag, ".err"}, 32'(out_err), 32'(q[0].e));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Single request followed by the range-check burst and its drain.
        tbl[0] = '{1, 1, 12'h123, 0, 0, 1, 12'h123, 0, 1, 0, 0};
        tbl[1] = '{1, 1, 12'h0FF, 0, 0, 1, 12'h123, 0, 2, 0, 0};
        tbl[2] = '{1, 1, 12'h100, 0, 0, 1, 12'h123, 0, 3, 0, 0};
        tbl[3] = '{1, 1, 12'h1FF, 0, 0, 1, 12'h123, 0, 4, 0, 0};
        tbl[4] = '{1, 1, 12'h200, 0, 0, 1, 12'h123, 0, 5, 0, 0};
        tbl[5] = '{1, 0, 12'h000, 1, 0, 1, 12'h0FF, 1, 4, 0, 0};
        tbl[6] = '{1, 0, 12'h000, 1, 0, 1, 12'h100, 0, 3, 0, 0};
        tbl[7] = '{1, 0, 12'h000, 1, 0, 1, 12'h1FF, 0, 2, 0, 0};
        tbl[8] = '{1, 0, 12'h000, 1, 0, 1, 12'h200, 1, 1, 0, 0};
        tbl[9] = '{1, 0, 12'h000, 1, 0, 0, 12'h200, 1, 0, 0, 0};

        #12;
        chk("rst.valid", 32'(out_valid), 0);
        chk("rst.level", 32'(level), 0);
        chk("rst.addr", 32'(out_addr), 0);
        chk("rst.err", 32'(out_err), 0);
        chk("rst.drop", 32'(drop_cnt), 0);
        chk("rst.ovf", 32'(ovf), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].en, tbl[i].v, tbl[i].a, tbl[i].r, tbl[i].c);
            chk($sformatf("tbl%0d.valid", i), 32'(out_valid), 32'(tbl[i].xv));
            chk($sformatf("tbl%0d.addr", i), 32'(out_addr), 32'(tbl[i].xa));
            chk($sformatf("tbl%0d.err", i), 32'(out_err), 32'(tbl[i].xe));
            chk($sformatf("tbl%0d.level", i), 32'(level), 32'(tbl[i].xl));
            chk($sformatf("tbl%0d.drop", i), 32'(drop_cnt), 32'(tbl[i].xd));
            chk($sformatf("tbl%0d.ovf", i), 32'(ovf), 32'(tbl[i].xo));
        end

        // Overflow: ten pushes into eight slots.
        for (int i = 0; i < 10; i++) drive(1, 1, 12'(i), 0, 0);
        chk("ovf.level", 32'(level), 8);
        chk("ovf.drop", 32'(drop_cnt), 2);
        chk("ovf.flag", 32'(ovf), 1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("ovf.drain%0d", i), 32'(out_addr), 32'(i));
            chk($sformatf("ovf.err%0d", i), 32'(out_err), 1);
            drive(0, 0, 12'h0, 1, 0);
        end
        chk("ovf.empty", 32'(out_valid), 0);
        drive(0, 0, 12'h0, 0, 1);
        chk("clr.flag", 32'(ovf), 0);
        chk("clr.drop", 32'(drop_cnt), 0);

        // Full with simultaneous push and pop.
        for (int i = 0; i < 8; i++) drive(1, 1, 12'h300 + 12'(i), 0, 0);
        chk("fpp.fill", 32'(level), 8);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("fpp.head%0d", i), 32'(out_addr), 32'(12'h300 + i));
            drive(1, 1, 12'h308 + 12'(i), 1, 0);
            chk($sformatf("fpp.level%0d", i), 32'(level), 8);
        end
        chk("fpp.drop", 32'(drop_cnt), 0);
        chk("fpp.flag", 32'(ovf), 0);
        for (int i = 4; i < 12; i++) begin
            chk($sformatf("fpp.drain%0d", i), 32'(out_addr), 32'(12'h300 + i));
            drive(0, 0, 12'h0, 1, 0);
        end
        chk("fpp.empty", 32'(level), 0);

        // Drop and clear in the same cycle: the drop wins.
        for (int i = 0; i < 8; i++) drive(1, 1, 12'h180 + 12'(i), 0, 0);
        drive(1, 1, 12'h1AA, 0, 0);
        drive(1, 1, 12'h1AB, 0, 0);
        chk("dc.drop2", 32'(drop_cnt), 2);
        drive(1, 1, 12'h1AC, 0, 1);
        chk("dc.drop1", 32'(drop_cnt), 1);
        chk("dc.flag", 32'(ovf), 1);

        // Asynchronous reset between edges while full.
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst.valid", 32'(out_valid), 0);
        chk("arst.level", 32'(level), 0);
        chk("arst.drop", 32'(drop_cnt), 0);
        chk("arst.flag", 32'(ovf), 0);
        q.delete();
        m_dc = 0;
        m_ov = 1'b0;
        #2;
        rst_n = 1'b1;
        drive(1, 1, 12'h155, 0, 0);
        chk("arst.head", 32'(out_addr), 32'h155);
        chk("arst.hvalid", 32'(out_valid), 1);
        chk("arst.hlevel", 32'(level), 1);

        // Enable gating while the stored entries drain.
        drive(1, 1, 12'h156, 0, 0);
        chk("gate.level2", 32'(level), 2);
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 12'h1F0 + 12'(i), 1, 0);
            check_model($sformatf("gate%0d", i));
        end
        chk("gate.level", 32'(level), 0);
        chk("gate.drop", 32'(drop_cnt), 0);

        // Random traffic against the queue model, alternating ready-starved and ready-rich phases.
        for (int i = 0; i < 3000; i++) begin
            int thr;
            thr = ((i / 200) % 2 == 0) ? 3 : 8;
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 2) != 0,
                  12'($urandom_range(0, 12'h2FF)), $urandom_range(0, 9) < thr,
                  $urandom_range(0, 49) == 0);
            check_model($sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
